// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
//   Transfer sequencer for the SPI master. Runs one DATA_W-bit full-duplex
//   transfer per accepted start request, covering all four CPOL/CPHA modes.
//   The clock prescaler is enabled through prescale_en and answers with a
//   one-cycle SCKTick per SCK half-period.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   start       transfer request, accepted only while busy=0
//   txData      word to send MSB-first, latched on accept
//   cpol/cpha   SPI mode, latched on accept
//   rxData      last received word, updated in the done cycle only
//   busy        transfer in progress
//   done        one-cycle pulse at end of transfer
//   prescaleEn  enable to the clock prescaler
//   SCKTick     one SCK half-period elapsed (from prescaler)
//   sck/mosi    SPI clock and data out
//   miso        SPI data in, already synchronised
//   cs_n        active-low chip select
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer; sck follows cpol input; waits for start
// LEAD  | cs_n asserted; one tick of CS setup before the first edge
// SHIFT | 2*DATA_W sck edges; data launched and sampled per mode
// TRAIL | sck back at idle level; one tick of CS hold, then done

module spi_xfer_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] txData,
    input  logic              cpol,
    input  logic              cpha,
    output logic [DATA_W-1:0] rxData,
    output logic              busy,
    output logic              done,
    output logic              prescaleEn,
    input  logic              SCKTick,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int                CNT_W     = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0]  LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  tx_sr;
    logic [DATA_W-1:0]  rx_sr;
    logic               cpol_q;
    logic               cpha_q;
    logic [CNT_W-1:0]   edge_cnt;

    logic               leading;
    logic               sample_now;
    logic               launch_now;

    // Even edge numbers leave the idle level (leading), odd ones return to it.
    // With cpha=1 the MSB is already on mosi from accept, so the first
    // leading edge launches nothing; with cpha=0 the final trailing edge has
    // no further bit to launch.
    always_comb begin
        leading    = ~edge_cnt[0];
        sample_now = cpha_q ? ~leading : leading;
        if (cpha_q) begin
            launch_now = leading && (edge_cnt != '0);
        end else begin
            launch_now = ~leading && (edge_cnt != LAST_EDGE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sck        <= 1'b0;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            prescaleEn <= 1'b0;
            rxData     <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            edge_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sck <= cpol;
                    if (start) begin
                        tx_sr      <= txData;
                        rx_sr      <= '0;
                        cpol_q     <= cpol;
                        cpha_q     <= cpha;
                        edge_cnt   <= '0;
                        cs_n       <= 1'b0;
                        busy       <= 1'b1;
                        prescaleEn <= 1'b1;
                        mosi       <= txData[DATA_W-1];
                        state      <= LEAD;
                    end
                end
                LEAD: begin
                    if (SCKTick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (SCKTick) begin
                        sck      <= ~sck;
                        edge_cnt <= edge_cnt + CNT_W'(1);
                        if (sample_now) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        end
                        if (launch_now) begin
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                            mosi  <= tx_sr[DATA_W-2];
                        end
                        if (edge_cnt == LAST_EDGE) begin
                            state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    // sck already rests at cpol_q here; hold cs_n for one tick.
                    if (SCKTick) begin
                        cs_n       <= 1'b1;
                        busy       <= 1'b0;
                        prescaleEn <= 1'b0;
                        done       <= 1'b1;
                        rxData     <= rx_sr;
                        mosi       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
